// File: rtl/warp_scheduler.sv
// warp_scheduler
// Owns both ports of the warp_table FIFO. Pops ready warps and offers them to
// fetch over a valid/ready handshake. Pushes returned (non-killed) warps and
// newly spawned warps back into the table, with returns taking priority.
// Tracks the number of active and in-flight warps.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   o_wt_read_en                pop request to warp_table
//   i_wt_read_data/valid        popped entry, valid the cycle after the pop
//   o_wt_write_en/data          push to warp_table
//   i_wt_fifo_empty/full        table flags
//   i_spawn_valid/data, o_spawn_ready          new warp admission
//   i_ret_valid/data/kill, o_ret_ready         warp returned by the pipeline
//   o_issue_valid/data, i_issue_ready          warp offered to fetch
//   o_active_warps, o_inflight_warps           registered warp counters
//   o_sched_idle                registered, high when no warp is active
// Entry format: [43:40] warp id, [39:32] active thread mask, [31:0] PC.
module warp_scheduler #(
    parameter int ENTRY_W   = 44,
    parameter int MAX_WARPS = 16,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               o_wt_read_en,
    input  logic [ENTRY_W-1:0] i_wt_read_data,
    input  logic               i_wt_read_valid,
    output logic               o_wt_write_en,
    output logic [ENTRY_W-1:0] o_wt_write_data,
    input  logic               i_wt_fifo_empty,
    input  logic               i_wt_fifo_full,
    input  logic               i_spawn_valid,
    input  logic [ENTRY_W-1:0] i_spawn_data,
    output logic               o_spawn_ready,
    input  logic               i_ret_valid,
    input  logic [ENTRY_W-1:0] i_ret_data,
    input  logic               i_ret_kill,
    output logic               o_ret_ready,
    output logic               o_issue_valid,
    output logic [ENTRY_W-1:0] o_issue_data,
    input  logic               i_issue_ready,
    output logic [CNT_W-1:0]   o_active_warps,
    output logic [CNT_W-1:0]   o_inflight_warps,
    output logic               o_sched_idle
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WARPS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ISSUE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ENTRY_W-1:0] r_issue_data;
    logic [CNT_W-1:0]   r_active;
    logic [CNT_W-1:0]   r_inflight;
    logic               r_sched_idle;

    logic               w_ret_hs;
    logic               w_ret_wr;
    logic               w_spawn_hs;
    logic               w_issue_hs;
    logic               w_load_issue;
    logic [CNT_W-1:0]   w_active_next;
    logic [CNT_W-1:0]   w_inflight_next;
    logic               w_act_inc;
    logic               w_act_dec;
    logic               w_inf_inc;
    logic               w_inf_dec;

    // ---------------- write-port arbitration ----------------
    // Grants are qualified with rst_n so every output reads 0 while reset is
    // held, even though the grants are combinational from the inputs.
    always_comb begin
        w_ret_hs   = rst_n & i_ret_valid & (i_ret_kill | ~i_wt_fifo_full);
        w_ret_wr   = w_ret_hs & ~i_ret_kill;
        // A killed return does not need the write port, so a spawn can share
        // the cycle with it.
        w_spawn_hs = rst_n & i_spawn_valid & ~(i_ret_valid & ~i_ret_kill)
                     & ~i_wt_fifo_full & (r_active < MAX_CNT);
    end

    assign o_ret_ready     = w_ret_hs;
    assign o_spawn_ready   = w_spawn_hs;
    assign o_wt_write_en   = w_ret_wr | w_spawn_hs;
    assign o_wt_write_data = !rst_n   ? '0 :
                             w_ret_wr ? i_ret_data : i_spawn_data;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_issue_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_issue) begin
                r_issue_data <= i_wt_read_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_wt_read_en = 1'b0;
        w_load_issue = 1'b0;
        w_issue_hs   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_wt_fifo_empty && rst_n) begin
                    o_wt_read_en = 1'b1;
                    w_state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (i_wt_read_valid) begin
                    w_load_issue = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_issue_ready) begin
                    w_issue_hs   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_issue_valid = (r_state == ST_ISSUE);
    assign o_issue_data  = r_issue_data;

    // ---------------- counters ----------------
    // A return seen with nothing in flight is a protocol error; it is dropped
    // from the count so the counter cannot wrap below zero.
    always_comb begin
        w_inf_inc = w_issue_hs & (r_inflight != MAX_CNT);
        w_inf_dec = w_ret_hs & (r_inflight != '0);
        w_act_inc = w_spawn_hs;
        w_act_dec = w_ret_hs & i_ret_kill & (r_active != '0);

        w_inflight_next = r_inflight;
        if (w_inf_inc && !w_inf_dec) begin
            w_inflight_next = r_inflight + CNT_W'(1);
        end else if (w_inf_dec && !w_inf_inc) begin
            w_inflight_next = r_inflight - CNT_W'(1);
        end

        w_active_next = r_active;
        if (w_act_inc && !w_act_dec) begin
            w_active_next = r_active + CNT_W'(1);
        end else if (w_act_dec && !w_act_inc) begin
            w_active_next = r_active - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active     <= '0;
            r_inflight   <= '0;
            r_sched_idle <= 1'b0;
        end else begin
            r_active     <= w_active_next;
            r_inflight   <= w_inflight_next;
            r_sched_idle <= (w_active_next == '0);
        end
    end

    assign o_active_warps   = r_active;
    assign o_inflight_warps = r_inflight;
    assign o_sched_idle     = r_sched_idle;

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler with a small queue-based warp_table model.
module tb_warp_scheduler;

    localparam int ENTRY_W = 44;
    localparam int CNT_W   = 5;

    logic               clk;
    logic               rst_n;
    logic               wt_read_en;
    logic [ENTRY_W-1:0] wt_read_data;
    logic               wt_read_valid;
    logic               wt_write_en;
    logic [ENTRY_W-1:0] wt_write_data;
    logic               wt_fifo_empty;
    logic               wt_fifo_full;
    logic               spawn_valid;
    logic [ENTRY_W-1:0] spawn_data;
    logic               spawn_ready;
    logic               ret_valid;
    logic [ENTRY_W-1:0] ret_data;
    logic               ret_kill;
    logic               ret_ready;
    logic               issue_valid;
    logic [ENTRY_W-1:0] issue_data;
    logic               issue_ready;
    logic [CNT_W-1:0]   active_warps;
    logic [CNT_W-1:0]   inflight_warps;
    logic               sched_idle;

    int n_checks = 0;
    int n_errors = 0;

    warp_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_wt_read_en     (wt_read_en),
        .i_wt_read_data   (wt_read_data),
        .i_wt_read_valid  (wt_read_valid),
        .o_wt_write_en    (wt_write_en),
        .o_wt_write_data  (wt_write_data),
        .i_wt_fifo_empty  (wt_fifo_empty),
        .i_wt_fifo_full   (wt_fifo_full),
        .i_spawn_valid    (spawn_valid),
        .i_spawn_data     (spawn_data),
        .o_spawn_ready    (spawn_ready),
        .i_ret_valid      (ret_valid),
        .i_ret_data       (ret_data),
        .i_ret_kill       (ret_kill),
        .o_ret_ready      (ret_ready),
        .o_issue_valid    (issue_valid),
        .o_issue_data     (issue_data),
        .i_issue_ready    (issue_ready),
        .o_active_warps   (active_warps),
        .o_inflight_warps (inflight_warps),
        .o_sched_idle     (sched_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // warp_table model: 16-deep FIFO, read data valid the cycle after the pop.
    logic [ENTRY_W-1:0] tbl_q[$];
    int                 tbl_size;
    logic               force_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q.delete();
            tbl_size      <= 0;
            wt_read_valid <= 1'b0;
            wt_read_data  <= '0;
        end else begin
            wt_read_valid <= 1'b0;
            if (wt_read_en && tbl_q.size() != 0) begin
                wt_read_data  <= tbl_q.pop_front();
                wt_read_valid <= 1'b1;
            end
            if (wt_write_en) begin
                tbl_q.push_back(wt_write_data);
            end
            tbl_size <= tbl_q.size();
        end
    end

    assign wt_fifo_empty = (tbl_size == 0);
    assign wt_fifo_full  = force_full | (tbl_size >= 16);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [ENTRY_W-1:0] S1 = 44'h1_01_00001000;
    localparam logic [ENTRY_W-1:0] R1 = 44'h1_01_00001004;
    localparam logic [ENTRY_W-1:0] S2 = 44'h2_0F_00002000;
    localparam logic [ENTRY_W-1:0] R2 = 44'h2_0F_00002010;
    localparam logic [ENTRY_W-1:0] S3 = 44'h3_FF_00003000;
    localparam logic [ENTRY_W-1:0] S4 = 44'h4_03_00004000;
    localparam logic [ENTRY_W-1:0] S17 = 44'hF_01_0000F000;
    localparam logic [ENTRY_W-1:0] R3 = 44'h4_03_00004008;

    initial begin
        logic [ENTRY_W-1:0] fill_data;
        rst_n       = 1'b1;
        force_full  = 1'b0;
        spawn_valid = 1'b1;
        spawn_data  = S1;
        ret_valid   = 1'b1;
        ret_data    = R1;
        ret_kill    = 1'b0;
        issue_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        // Reset: every output 0 even with requests pending.
        chk("rst_read_en", 64'(wt_read_en), 64'd0);
        chk("rst_write_en", 64'(wt_write_en), 64'd0);
        chk("rst_write_data", 64'(wt_write_data), 64'd0);
        chk("rst_spawn_ready", 64'(spawn_ready), 64'd0);
        chk("rst_ret_ready", 64'(ret_ready), 64'd0);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_issue_data", 64'(issue_data), 64'd0);
        chk("rst_active", 64'(active_warps), 64'd0);
        chk("rst_inflight", 64'(inflight_warps), 64'd0);
        chk("rst_idle", 64'(sched_idle), 64'd0);
        step();
        spawn_valid = 1'b0;
        ret_valid   = 1'b0;
        rst_n       = 1'b1;
        step();
        chk("post_rst_idle", 64'(sched_idle), 64'd1);
        chk("post_rst_read_en", 64'(wt_read_en), 64'd0);

        // First spawn and issue.
        spawn_valid = 1'b1;
        spawn_data  = S1;
        #1;
        chk("s1_spawn_ready", 64'(spawn_ready), 64'd1);
        chk("s1_write_en", 64'(wt_write_en), 64'd1);
        chk("s1_write_data", 64'(wt_write_data), 64'(S1));
        chk("s1_ret_ready", 64'(ret_ready), 64'd0);
        step();
        spawn_valid = 1'b0;
        #1;
        chk("s1_active", 64'(active_warps), 64'd1);
        chk("s1_idle", 64'(sched_idle), 64'd0);
        chk("s1_pop", 64'(wt_read_en), 64'd1);
        step();
        chk("s1_pop_once", 64'(wt_read_en), 64'd0);
        chk("s1_not_issued_yet", 64'(issue_valid), 64'd0);
        step();
        chk("s1_issue_valid", 64'(issue_valid), 64'd1);
        chk("s1_issue_data", 64'(issue_data), 64'(S1));

        // Backpressure from fetch for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", 64'(issue_valid), 64'd1);
            chk("hold_data", 64'(issue_data), 64'(S1));
            chk("hold_no_pop", 64'(wt_read_en), 64'd0);
        end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        chk("s1_inflight", 64'(inflight_warps), 64'd1);
        chk("s1_issue_done", 64'(issue_valid), 64'd0);
        chk("s1_empty_no_pop", 64'(wt_read_en), 64'd0);

        // Non-kill return is re-enqueued and reissued.
        ret_valid = 1'b1;
        ret_data  = R1;
        ret_kill  = 1'b0;
        #1;
        chk("r1_ret_ready", 64'(ret_ready), 64'd1);
        chk("r1_write_en", 64'(wt_write_en), 64'd1);
        chk("r1_write_data", 64'(wt_write_data), 64'(R1));
        step();
        ret_valid = 1'b0;
        #1;
        chk("r1_inflight0", 64'(inflight_warps), 64'd0);
        chk("r1_active", 64'(active_warps), 64'd1);
        chk("r1_pop", 64'(wt_read_en), 64'd1);
        step();
        step();
        chk("r1_issue_valid", 64'(issue_valid), 64'd1);
        chk("r1_issue_data", 64'(issue_data), 64'(R1));
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        chk("r1_inflight1", 64'(inflight_warps), 64'd1);

        // Killed return.
        ret_valid = 1'b1;
        ret_kill  = 1'b1;
        ret_data  = R1;
        #1;
        chk("kill_ret_ready", 64'(ret_ready), 64'd1);
        chk("kill_write_en", 64'(wt_write_en), 64'd0);
        step();
        ret_valid = 1'b0;
        ret_kill  = 1'b0;
        #1;
        chk("kill_active", 64'(active_warps), 64'd0);
        chk("kill_inflight", 64'(inflight_warps), 64'd0);
        chk("kill_idle", 64'(sched_idle), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("kill_no_pop", 64'(wt_read_en), 64'd0);
        end

        // Spawn S2 and issue it.
        spawn_valid = 1'b1;
        spawn_data  = S2;
        step();
        spawn_valid = 1'b0;
        step();
        step();
        chk("s2_issue_data", 64'(issue_data), 64'(S2));
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        chk("s2_inflight", 64'(inflight_warps), 64'd1);

        // Same-cycle spawn and non-kill return: return wins the write port.
        ret_valid   = 1'b1;
        ret_data    = R2;
        ret_kill    = 1'b0;
        spawn_valid = 1'b1;
        spawn_data  = S3;
        #1;
        chk("arb_ret_ready", 64'(ret_ready), 64'd1);
        chk("arb_spawn_blocked", 64'(spawn_ready), 64'd0);
        chk("arb_write_data_ret", 64'(wt_write_data), 64'(R2));
        step();
        ret_valid = 1'b0;
        #1;
        chk("arb_spawn_next", 64'(spawn_ready), 64'd1);
        chk("arb_write_en", 64'(wt_write_en), 64'd1);
        chk("arb_write_data_spawn", 64'(wt_write_data), 64'(S3));
        chk("arb_inflight", 64'(inflight_warps), 64'd0);
        chk("arb_pop_with_push", 64'(wt_read_en), 64'd1);
        step();
        spawn_valid = 1'b0;
        #1;
        chk("arb_active", 64'(active_warps), 64'd2);
        step();
        chk("r2_issue_valid", 64'(issue_valid), 64'd1);
        chk("r2_issue_data", 64'(issue_data), 64'(R2));
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        chk("r2_inflight", 64'(inflight_warps), 64'd1);
        chk("s3_pop", 64'(wt_read_en), 64'd1);
        step();
        step();
        chk("s3_issue_data", 64'(issue_data), 64'(S3));
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        #1;
        chk("s3_inflight", 64'(inflight_warps), 64'd2);

        // Same-cycle spawn and killed return: both accepted.
        ret_valid   = 1'b1;
        ret_kill    = 1'b1;
        ret_data    = R2;
        spawn_valid = 1'b1;
        spawn_data  = S4;
        #1;
        chk("ks_ret_ready", 64'(ret_ready), 64'd1);
        chk("ks_spawn_ready", 64'(spawn_ready), 64'd1);
        chk("ks_write_en", 64'(wt_write_en), 64'd1);
        chk("ks_write_data", 64'(wt_write_data), 64'(S4));
        step();
        ret_valid   = 1'b0;
        ret_kill    = 1'b0;
        spawn_valid = 1'b0;
        #1;
        chk("ks_active", 64'(active_warps), 64'd2);
        chk("ks_inflight", 64'(inflight_warps), 64'd1);
        chk("ks_pop", 64'(wt_read_en), 64'd1);
        step();
        step();
        chk("s4_issue_valid", 64'(issue_valid), 64'd1);
        chk("s4_issue_data", 64'(issue_data), 64'(S4));

        // Fill to MAX_WARPS active warps.
        for (int i = 0; i < 14; i++) begin
            fill_data   = S17;
            fill_data[43:40] = 4'(i);
            fill_data[31:0]  = 32'h5000 + 32'(i);
            spawn_valid = 1'b1;
            spawn_data  = fill_data;
            #1;
            chk("fill_spawn_ready", 64'(spawn_ready), 64'd1);
            step();
        end
        spawn_data = S17;
        #1;
        chk("full_active16", 64'(active_warps), 64'd16);
        chk("full_spawn17_held", 64'(spawn_ready), 64'd0);
        chk("full_spawn17_no_wr", 64'(wt_write_en), 64'd0);

        // Non-kill return against a full table waits for space.
        force_full = 1'b1;
        ret_valid  = 1'b1;
        ret_kill   = 1'b0;
        ret_data   = R3;
        #1;
        chk("tfull_ret_blocked", 64'(ret_ready), 64'd0);
        chk("tfull_no_write", 64'(wt_write_en), 64'd0);
        step();
        chk("tfull_ret_still_blocked", 64'(ret_ready), 64'd0);
        chk("tfull_inflight", 64'(inflight_warps), 64'd1);
        force_full = 1'b0;
        #1;
        chk("tfree_ret_ready", 64'(ret_ready), 64'd1);
        chk("tfree_write_data", 64'(wt_write_data), 64'(R3));
        chk("tfree_spawn_held", 64'(spawn_ready), 64'd0);
        step();
        chk("tfree_inflight", 64'(inflight_warps), 64'd0);
        chk("tfree_issue_held", 64'(issue_data), 64'(S4));
        chk("tfree_issue_valid", 64'(issue_valid), 64'd1);

        // Reset asserted mid-ISSUE with requests still pending.
        spawn_valid = 1'b1;
        ret_valid   = 1'b1;
        ret_kill    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_issue_valid", 64'(issue_valid), 64'd0);
        chk("mrst_issue_data", 64'(issue_data), 64'd0);
        chk("mrst_active", 64'(active_warps), 64'd0);
        chk("mrst_inflight", 64'(inflight_warps), 64'd0);
        chk("mrst_spawn_ready", 64'(spawn_ready), 64'd0);
        chk("mrst_ret_ready", 64'(ret_ready), 64'd0);
        chk("mrst_write_en", 64'(wt_write_en), 64'd0);
        chk("mrst_read_en", 64'(wt_read_en), 64'd0);
        chk("mrst_idle", 64'(sched_idle), 64'd0);
        step();
        spawn_valid = 1'b0;
        ret_valid   = 1'b0;
        ret_kill    = 1'b0;
        rst_n       = 1'b1;
        step();
        chk("end_idle", 64'(sched_idle), 64'd1);
        chk("end_issue_valid", 64'(issue_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
